msu_data_prefetch: RTL and testbench

MSU-1 data-port prefetch buffer, sitting directly downstream of the MSU register block. It consumes the seek address, seek pulse and per-read advance pulse. It returns the current data byte and the data-busy status. It fetches 16-bit little-endian words from the MSU data-file memory backend into a small byte FIFO, so each SNES read of $2001 is served with zero wait.

---
 rtl/msu_pkg.sv | 16 +
 rtl/msu_byte_fifo.sv | 83 ++++++++
 rtl/msu_data_prefetch.sv | 162 ++++++++++++++++
 tb/tb_msu_data_prefetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msu_pkg.sv
// Shared definitions for the MSU-1 data-port prefetch slice.
//   msu_state_e       : prefetch FSM states (IDLE, FETCH, DISCARD)
//   MSU_MEM_WIDTH     : width of one data-file memory word
//   MSU_DEFAULT_DEPTH : default byte FIFO capacity
package msu_pkg;

  localparam int unsigned MSU_MEM_WIDTH     = 16;
  localparam int unsigned MSU_DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } msu_state_e;

endpackage

// File: rtl/msu_byte_fifo.sv
// Byte FIFO with a registered head byte, fed by up to two bytes per cycle.
// Ports:
//   CLK, RESET  : clock, synchronous active-high reset
//   flush_i     : empties the FIFO (head_o keeps its last value)
//   push_cnt_i  : number of bytes to push this cycle (0, 1 or 2)
//   push_data_i : [7:0] is pushed first, [15:8] second
//   pop_i       : drop the head byte; ignored while empty
//   head_o      : registered current head byte
//   count_o     : number of bytes held
module msu_byte_fifo
  import msu_pkg::*;
#(
  parameter int unsigned DEPTH = MSU_DEFAULT_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     flush_i,
  input  logic [1:0]               push_cnt_i,
  input  logic [MSU_MEM_WIDTH-1:0] push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, wr_nx;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          do_pop;

  assign wr_nx  = wr_q + AW'(1);
  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    head_d  = head_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_pop) rd_d = rd_q + AW'(1);
      wr_d    = wr_q + AW'(push_cnt_i);
      count_d = count_q + CW'(push_cnt_i) - CW'(do_pop);
      // Head points at the slot being written only when the FIFO drains to
      // empty this cycle, so the new head then comes straight from the push.
      if (count_d != '0) begin
        if ((push_cnt_i != 2'd0) && (rd_d == wr_q)) head_d = push_data_i[7:0];
        else                                        head_d = mem_q[rd_d];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!flush_i) begin
      if (push_cnt_i != 2'd0) mem_q[wr_q]  <= push_data_i[7:0];
      if (push_cnt_i == 2'd2) mem_q[wr_nx] <= push_data_i[15:8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/msu_data_prefetch.sv
// MSU-1 data-port prefetch: streams 16-bit little-endian words from the data
// file memory into a byte FIFO so every $2001 read is served without waiting.
// Ports:
//   CLK, RESET           : clock, synchronous active-high reset
//   msu_data_addr/seek   : start a new stream at a byte address
//   msu_data_req         : current byte consumed, advance
//   msu_data_out         : registered current byte
//   msu_status_data_busy : seek issued, first byte not yet available
//   mem_req/addr/ack/data: word-fetch handshake to the memory backend
//   underrun_count       : saturating underrun counter, only with
//                          MSU_DATA_PREFETCH_STATS_EN defined
module msu_data_prefetch
  import msu_pkg::*;
#(
  parameter int unsigned DEPTH = MSU_DEFAULT_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              msu_data_addr,
  input  logic                     msu_data_seek,
  input  logic                     msu_data_req,
  output logic [7:0]               msu_data_out,
  output logic                     msu_status_data_busy,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [MSU_MEM_WIDTH-1:0] mem_data
`ifdef MSU_DATA_PREFETCH_STATS_EN
  ,
  output logic [15:0]              underrun_count
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  msu_state_e state_q, state_d;
  logic [31:0] fetch_ptr_q, fetch_ptr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        skip_low_q, skip_low_d;
  logic        stream_valid_q, stream_valid_d;
  logic        busy_q, busy_d;

  logic [1:0]               push_cnt;
  logic [MSU_MEM_WIDTH-1:0] push_data;
  logic                     pop;
  logic [CW-1:0]            count;
  logic [CW-1:0]            free;

  assign free = CW'(DEPTH) - count;
  // A seek takes priority over a coincident read.
  assign pop  = msu_data_req && !msu_data_seek;

  always_comb begin
    state_d        = state_q;
    fetch_ptr_d    = fetch_ptr_q;
    mem_addr_d     = mem_addr_q;
    skip_low_d     = skip_low_q;
    stream_valid_d = stream_valid_q;
    busy_d         = busy_q;
    push_cnt       = 2'd0;
    push_data      = mem_data;

    case (state_q)
      IDLE: begin
        // Needing two free slots means a full word always fits.
        if (stream_valid_q && (free >= CW'(2))) begin
          state_d    = FETCH;
          mem_addr_d = fetch_ptr_q;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          state_d     = IDLE;
          fetch_ptr_d = fetch_ptr_q + 32'd2;
          skip_low_d  = 1'b0;
          busy_d      = 1'b0;
          if (skip_low_q) begin
            push_cnt  = 2'd1;
            push_data = {8'h00, mem_data[15:8]};
          end else begin
            push_cnt  = 2'd2;
          end
        end
      end
      DISCARD: begin
        // Word belongs to the abandoned stream.
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (msu_data_seek) begin
      push_cnt       = 2'd0;
      fetch_ptr_d    = {msu_data_addr[31:1], 1'b0};
      skip_low_d     = msu_data_addr[0];
      stream_valid_d = 1'b1;
      busy_d         = 1'b1;
      if (state_q == IDLE) begin
        state_d    = FETCH;
        mem_addr_d = {msu_data_addr[31:1], 1'b0};
      end else if (mem_ack) begin
        state_d = IDLE;
      end else begin
        // The old request must complete before the new stream can start.
        state_d = DISCARD;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= IDLE;
      fetch_ptr_q    <= '0;
      mem_addr_q     <= '0;
      skip_low_q     <= 1'b0;
      stream_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_ptr_q    <= fetch_ptr_d;
      mem_addr_q     <= mem_addr_d;
      skip_low_q     <= skip_low_d;
      stream_valid_q <= stream_valid_d;
      busy_q         <= busy_d;
    end
  end

  msu_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .flush_i     (msu_data_seek),
    .push_cnt_i  (push_cnt),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (msu_data_out),
    .count_o     (count)
  );

  assign mem_req              = (state_q != IDLE);
  assign mem_addr             = mem_addr_q;
  assign msu_status_data_busy = busy_q;

`ifdef MSU_DATA_PREFETCH_STATS_EN
  logic        underrun;
  logic [15:0] underrun_q;

  assign underrun = pop && (count == '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      underrun_q <= '0;
    end else if (underrun && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_count = underrun_q;
`endif

endmodule

// File: tb/tb_msu_data_prefetch.sv
module tb_msu_data_prefetch;

  localparam int unsigned DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] msu_data_addr;
  logic        msu_data_seek;
  logic        msu_data_req;
  logic [7:0]  msu_data_out;
  logic        msu_status_data_busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
`ifdef MSU_DATA_PREFETCH_STATS_EN
  logic [15:0] underrun_count;
`endif

  always #5 CLK = ~CLK;

  msu_data_prefetch #(
    .DEPTH (DEPTH)
  ) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .msu_data_addr        (msu_data_addr),
    .msu_data_seek        (msu_data_seek),
    .msu_data_req         (msu_data_req),
    .msu_data_out         (msu_data_out),
    .msu_status_data_busy (msu_status_data_busy),
    .mem_req              (mem_req),
    .mem_addr             (mem_addr),
    .mem_ack              (mem_ack),
    .mem_data             (mem_data)
`ifdef MSU_DATA_PREFETCH_STATS_EN
    ,
    .underrun_count       (underrun_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stream model: the byte at stream position k is byte_at(s_addr + k).
  logic [31:0] s_addr;
  int unsigned pushed;
  int unsigned popped;
  int unsigned underruns;
  logic        stale;
  logic        prev_req;

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_ack(input logic [15:0] data);
    mem_ack  = 1'b1;
    mem_data = data;
    tick();
    mem_ack  = 1'b0;
  endtask

  task automatic do_seek(input logic [31:0] a);
    msu_data_addr = a;
    msu_data_seek = 1'b1;
    tick();
    msu_data_seek = 1'b0;
  endtask

  // Random traffic against the stream model. Memory answers from byte_at().
  task automatic engine(input int cycles, input int req_pct, input int ack_pct,
                        input int seek_pct, input bit first_seek, input logic [31:0] first_addr);
    prev_req = mem_req;
    for (int i = 0; i < cycles; i++) begin
      logic        sk, rq, ak;
      logic [31:0] sa, pos, w;
      if (mem_req && !prev_req) stale = 1'b0;
      if (!(first_seek && i == 0)) begin
        if (pushed > popped) check("eng_data", msu_data_out, byte_at(s_addr + popped));
        check("eng_busy", msu_status_data_busy, pushed == 0);
      end
      sk = (first_seek && i == 0) || (($urandom % 100) < seek_pct);
      sa = (first_seek && i == 0) ? first_addr : $urandom;
      rq = ($urandom % 100) < req_pct;
      ak = mem_req && (($urandom % 100) < ack_pct);
      w  = mem_addr;
      msu_data_seek = sk;
      msu_data_addr = sa;
      msu_data_req  = rq;
      mem_ack       = ak;
      mem_data      = {byte_at(w + 32'd1), byte_at(w)};
      if (sk) begin
        s_addr = sa;
        pushed = 0;
        popped = 0;
        if (mem_req) stale = 1'b1;
      end else begin
        if (rq) begin
          if (pushed > popped) popped++;
          else underruns++;
        end
        if (ak && !stale) begin
          pos = s_addr + pushed;
          check("eng_addr", mem_addr, {pos[31:1], 1'b0});
          pushed += pos[0] ? 1 : 2;
        end
      end
      prev_req = mem_req;
      tick();
    end
    msu_data_seek = 1'b0;
    msu_data_req  = 1'b0;
    mem_ack       = 1'b0;
  endtask

  initial begin
    int n;
    RESET         = 1'b1;
    msu_data_addr = '0;
    msu_data_seek = 1'b0;
    msu_data_req  = 1'b0;
    mem_ack       = 1'b0;
    mem_data      = '0;
    stale         = 1'b0;
    underruns     = 0;
    pushed        = 0;
    popped        = 0;
    s_addr        = '0;
    repeat (3) tick();
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_out", msu_data_out, 0);
    check("rst_busy", msu_status_data_busy, 0);
    RESET = 1'b0;
    repeat (4) tick();
    check("idle_no_fetch", mem_req, 0);

    // Even seek
    do_seek(32'h0000_1000);
    check("even_req", mem_req, 1);
    check("even_addr", mem_addr, 32'h1000);
    check("even_busy", msu_status_data_busy, 1);
    tick();
    check("even_busy_hold", msu_status_data_busy, 1);
    do_ack(16'hBBAA);
    check("even_out", msu_data_out, 8'hAA);
    check("even_busy_fall", msu_status_data_busy, 0);
    check("even_req_drop", mem_req, 0);
    msu_data_req = 1'b1;
    tick();
    msu_data_req = 1'b0;
    check("even_pop", msu_data_out, 8'hBB);
    check("even_next_req", mem_req, 1);
    check("even_next_addr", mem_addr, 32'h1002);

    // Odd seek while the 0x1002 fetch is outstanding
    do_seek(32'h0000_0003);
    check("odd_hold_req", mem_req, 1);
    check("odd_hold_addr", mem_addr, 32'h1002);
    check("odd_busy", msu_status_data_busy, 1);
    do_ack(16'h9999);
    check("odd_drop_req", mem_req, 0);
    check("odd_busy_discard", msu_status_data_busy, 1);
    tick();
    check("odd_req", mem_req, 1);
    check("odd_addr", mem_addr, 32'h0002);
    do_ack(16'h5544);
    check("odd_out", msu_data_out, 8'h55);
    check("odd_busy_fall", msu_status_data_busy, 0);
    tick();
    check("odd_next_addr", mem_addr, 32'h0004);
    do_ack(16'h7766);
    msu_data_req = 1'b1;
    tick();
    msu_data_req = 1'b0;
    check("odd_single_push", msu_data_out, 8'h66);
    check("odd_addr6", mem_addr, 32'h0006);
    do_ack(16'hAAAA);

    // Seek from IDLE, then re-seek before the ack
    do_seek(32'h0000_0100);
    check("sk1_addr", mem_addr, 32'h100);
    check("sk1_busy", msu_status_data_busy, 1);
    do_seek(32'h0000_0200);
    check("sk2_hold_addr", mem_addr, 32'h100);
    do_ack(16'h1111);
    check("sk2_drop_req", mem_req, 0);
    check("sk2_busy", msu_status_data_busy, 1);
    tick();
    check("sk2_addr", mem_addr, 32'h200);
    check("sk2_busy2", msu_status_data_busy, 1);
    do_ack(16'h2322);
    check("sk2_out", msu_data_out, 8'h22);
    check("sk2_busy_fall", msu_status_data_busy, 0);

    // Address wrap
    do_seek(32'hFFFF_FFFE);
    check("wrap_addr", mem_addr, 32'hFFFF_FFFE);
    do_ack(16'h3412);
    check("wrap_out", msu_data_out, 8'h12);
    tick();
    check("wrap_next_req", mem_req, 1);
    check("wrap_next_addr", mem_addr, 32'h0);

    // Underrun: drain both bytes, then one read with the FIFO empty
    msu_data_req = 1'b1;
    tick();
    check("ur_pop1", msu_data_out, 8'h34);
    tick();
    tick();
    msu_data_req = 1'b0;
    check("ur_hold", msu_data_out, 8'h34);
    check("ur_busy", msu_status_data_busy, 0);
    do_ack(16'h7856);
    check("ur_align", msu_data_out, 8'h56);
    check("ur_req_drop", mem_req, 0);
`ifdef MSU_DATA_PREFETCH_STATS_EN
    check("ur_count", underrun_count, 1);
`endif

    // Fill with instant acks and no reads: stops at DEPTH bytes
    engine(60, 0, 100, 0, 1'b1, 32'h0000_4000);
    check("fill_level", pushed - popped, DEPTH);
    check("fill_stop", mem_req, 0);
    engine(2, 100, 100, 0, 1'b0, 32'h0);
    engine(10, 0, 100, 0, 1'b0, 32'h0);
    check("fill_resume", pushed, DEPTH + 2);

    // Sequential reads with instant acks
    engine(400, 60, 100, 0, 1'b0, 32'h0);
    check("seq_reads", popped >= 64, 1);

    // Random reads, acks and seeks
    engine(3000, 40, 30, 3, 1'b1, 32'h0000_8001);
    engine(1000, 70, 50, 2, 1'b1, 32'hFFFF_FFF9);
`ifdef MSU_DATA_PREFETCH_STATS_EN
    check("stats_total", underrun_count, 1 + underruns);
`endif

    // Reset mid-fetch, followed by a late ack
    do_seek(32'h0000_0040);
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    check("rmid_req_before", mem_req, 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("rmid_req_drop", mem_req, 0);
    do_ack(16'hEEEE);
    check("rmid_late_ack_req", mem_req, 0);
    check("rmid_out", msu_data_out, 0);
    check("rmid_busy", msu_status_data_busy, 0);
    tick();
    check("rmid_no_fetch", mem_req, 0);
`ifdef MSU_DATA_PREFETCH_STATS_EN
    check("rmid_stats", underrun_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
